// File: rtl/aes_key_schedule_seq_if.sv
// rtl/aes_key_schedule_seq_if.sv - start/done and round-key read bus of the AES key schedule
interface aes_key_schedule_seq_if #(
    parameter int MAX_KEY_BITS = 256
);
    logic                    start;
    logic [1:0]              mode_in;
    logic [MAX_KEY_BITS-1:0] key_in;
    logic                    ready;
    logic                    busy;
    logic                    done;
    logic                    err;
    logic [3:0]              nr;
    logic [3:0]              rk_idx;
    logic [127:0]            rk_out;

    modport master (
        output start, mode_in, key_in, rk_idx,
        input  ready, busy, done, err, nr, rk_out
    );

    modport slave (
        input  start, mode_in, key_in, rk_idx,
        output ready, busy, done, err, nr, rk_out
    );
endinterface

// File: rtl/aes_key_schedule_seq.sv
// rtl/aes_key_schedule_seq.sv - sequential AES-128/192/256 key expansion, one word per clock
module aes_key_schedule_seq #(
    parameter int MAX_KEY_BITS = 256,
    parameter bit RK_REG_OUT   = 1'b1
) (
    input logic                   CLK,
    input logic                   RST,
    aes_key_schedule_seq_if.slave bus
);
    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t        state;
    logic [31:0]   w [0:59];
    logic [5:0]    widx;       // index of the word written on the next EXPAND edge
    logic [2:0]    pos;        // widx mod nk, tracked incrementally
    logic [3:0]    nk;
    logic [5:0]    last_idx;
    logic [7:0]    rcon;
    logic          ready_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic [3:0]    nr_q;

    logic [255:0]  key_pad;
    logic [9:0]    key_bits;
    logic          mode_ok;
    logic [3:0]    nk_sel;
    logic [3:0]    nr_sel;
    logic [5:0]    last_sel;
    logic [31:0]   prev_word;
    logic [31:0]   back_word;
    logic [31:0]   sub_in;
    logic [31:0]   sub_out;
    logic [31:0]   new_word;
    logic [7:0]    rcon_next;
    logic [5:0]    rd_base;
    logic [127:0]  rd_data;

    // Key is MSB-aligned on the bus; left-justify it into 256 bits so word j is always the same slice.
    assign key_pad  = 256'(bus.key_in) << (256 - MAX_KEY_BITS);
    assign key_bits = 10'd128 + 10'({bus.mode_in, 6'b0});
    assign mode_ok  = (bus.mode_in != 2'b11) && (int'(key_bits) <= MAX_KEY_BITS);
    assign nk_sel   = 4'd4 + {1'b0, bus.mode_in, 1'b0};
    assign nr_sel   = 4'd10 + {1'b0, bus.mode_in, 1'b0};
    assign last_sel = 6'd43 + {1'b0, bus.mode_in, 3'b0};
    assign rcon_next = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

    // Next schedule word from the single shared SubWord unit.
    always_comb begin
        prev_word = w[widx - 6'd1];
        back_word = w[widx - {2'b00, nk}];
        sub_in    = (pos == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
        sub_out   = '0;
        for (int b = 0; b < 4; b++) begin
            sub_out[8*b +: 8] = SBOX[sub_in[8*b +: 8]];
        end
        if (pos == 3'd0) begin
            new_word = back_word ^ sub_out ^ {rcon, 24'h0};
        end else if (nk == 4'd8 && pos == 3'd4) begin
            new_word = back_word ^ sub_out;
        end else begin
            new_word = back_word ^ prev_word;
        end
    end

    // Control FSM, word store and registered status outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            nr_q     <= 4'd10;
            widx     <= 6'd0;
            pos      <= 3'd0;
            nk       <= 4'd4;
            last_idx <= 6'd43;
            rcon     <= 8'h01;
            for (int i = 0; i < 60; i++) begin
                w[i] <= 32'h0;
            end
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        if (mode_ok) begin
                            nk       <= nk_sel;
                            nr_q     <= nr_sel;
                            last_idx <= last_sel;
                            for (int j = 0; j < 8; j++) begin
                                if (j < int'(nk_sel)) begin
                                    w[j] <= key_pad[255-32*j -: 32];
                                end
                            end
                            widx    <= nk_sel[3:0] + 6'd0;
                            pos     <= 3'd0;
                            rcon    <= 8'h01;
                            busy_q  <= 1'b1;
                            ready_q <= 1'b0;
                            state   <= EXPAND;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                EXPAND: begin
                    w[widx] <= new_word;
                    if (pos == 3'd0) begin
                        rcon <= rcon_next;
                    end
                    pos  <= ({1'b0, pos} == nk - 4'd1) ? 3'd0 : pos + 3'd1;
                    widx <= widx + 6'd1;
                    if (widx == last_idx) begin
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                        state   <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign bus.nr    = nr_q;

    // Round-key gather; out-of-range index or keys not ready read as zero.
    always_comb begin
        rd_base = {bus.rk_idx, 2'b00};
        rd_data = '0;
        if (ready_q && bus.rk_idx <= nr_q) begin
            rd_data = {w[rd_base], w[rd_base + 6'd1], w[rd_base + 6'd2], w[rd_base + 6'd3]};
        end
    end

    generate
        if (RK_REG_OUT) begin : g_rk_reg
            logic [127:0] rk_q;
            // One-cycle registered read port.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    rk_q <= '0;
                end else begin
                    rk_q <= rd_data;
                end
            end
            assign bus.rk_out = rk_q;
        end else begin : g_rk_comb
            assign bus.rk_out = rd_data;
        end
    endgenerate
endmodule
